vga_timing_gen: RTL and testbench

Pixel-timing generator for the VGA output path. It divides the system clock down to a pixel-rate enable and runs the horizontal and vertical scan counters. It drives hsync, vsync, video_on and the current pixel coordinates to the text/graphics renderers and to the RGB output register, which all sample on `p_tick`. Default timing is 640x480 @ 60 Hz from a 100 MHz `clk`, giving a 25 MHz pixel rate.

---
 rtl/vga_timing_pkg.sv | 23 ++
 rtl/pixel_tick_div.sv | 26 ++
 rtl/vga_timing_gen.sv | 81 ++++++++
 tb/tb_vga_timing_gen.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and helpers for the scan generator.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;

  // 640x480 @ 60 Hz from a 100 MHz clock.
  localparam int unsigned DEF_TICK_DIV  = 4;
  localparam int unsigned DEF_H_DISPLAY = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_DISPLAY = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  // Total count of one scan axis (line length in pixels or frame length in lines).
  function automatic int unsigned scan_total(input int unsigned disp, input int unsigned front,
                                             input int unsigned sync, input int unsigned back);
    return disp + front + sync + back;
  endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Clock-enable divider: p_tick is high for one clk out of every TICK_DIV.
module pixel_tick_div #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign p_tick = (cnt_q == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (p_tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA scan generator: pixel-rate enable, h/v counters and aligned sync/blanking outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
  parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK
) (
  input  logic               clk,
  input  logic               reset,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               p_tick,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               line_end,
  output logic               frame_end
);

  localparam int unsigned H_TOTAL  = scan_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL  = scan_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
  localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [COORD_W-1:0] x_q, y_q, x_next, y_next;
  logic               h_last, v_last;

  pixel_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick)
  );

  assign h_last    = (x_q == COORD_W'(H_TOTAL - 1));
  assign v_last    = (y_q == COORD_W'(V_TOTAL - 1));
  assign line_end  = p_tick && h_last;
  assign frame_end = line_end && v_last;
  assign pixel_x   = x_q;
  assign pixel_y   = y_q;

  // Next scan position; holds between pixel ticks.
  always_comb begin
    x_next = x_q;
    y_next = y_q;
    if (p_tick) begin
      if (h_last) begin
        x_next = '0;
        y_next = v_last ? '0 : y_q + COORD_W'(1);
      end else begin
        x_next = x_q + COORD_W'(1);
      end
    end
  end

  // Syncs and blanking decode the next position so they line up with the counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q      <= '0;
      y_q      <= '0;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      video_on <= 1'b1;
    end else begin
      x_q      <= x_next;
      y_q      <= y_next;
      hsync    <= !((x_next >= COORD_W'(HS_START)) && (x_next < COORD_W'(HS_END)));
      vsync    <= !((y_next >= COORD_W'(VS_START)) && (y_next < COORD_W'(VS_END)));
      video_on <= (x_next < COORD_W'(H_DISPLAY)) && (y_next < COORD_W'(V_DISPLAY));
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default, reduced and TICK_DIV=1 builds against an arithmetic scan model.
module tb_vga_timing_gen;

  localparam int S_DIV = 3;
  localparam int S_HD = 20, S_HF = 4, S_HS = 6, S_HB = 5;
  localparam int S_VD = 12, S_VF = 2, S_VS = 3, S_VB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   k;

  logic hs_d, vs_d, von_d, pt_d, le_d, fe_d;
  logic hs_s, vs_s, von_s, pt_s, le_s, fe_s;
  logic hs_1, vs_1, von_1, pt_1, le_1, fe_1;
  logic [9:0] x_d, y_d, x_s, y_s, x_1, y_1;
  logic [25:0] obs_d, obs_s, obs_1;

  assign obs_d = {hs_d, vs_d, von_d, pt_d, le_d, fe_d, x_d, y_d};
  assign obs_s = {hs_s, vs_s, von_s, pt_s, le_s, fe_s, x_s, y_s};
  assign obs_1 = {hs_1, vs_1, von_1, pt_1, le_1, fe_1, x_1, y_1};

  vga_timing_gen dut_d (
    .clk(clk), .reset(reset), .hsync(hs_d), .vsync(vs_d), .video_on(von_d), .p_tick(pt_d),
    .pixel_x(x_d), .pixel_y(y_d), .line_end(le_d), .frame_end(fe_d)
  );

  vga_timing_gen #(
    .TICK_DIV(S_DIV), .H_DISPLAY(S_HD), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_DISPLAY(S_VD), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
  ) dut_s (
    .clk(clk), .reset(reset), .hsync(hs_s), .vsync(vs_s), .video_on(von_s), .p_tick(pt_s),
    .pixel_x(x_s), .pixel_y(y_s), .line_end(le_s), .frame_end(fe_s)
  );

  vga_timing_gen #(
    .TICK_DIV(1), .H_DISPLAY(S_HD), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_DISPLAY(S_VD), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
  ) dut_1 (
    .clk(clk), .reset(reset), .hsync(hs_1), .vsync(vs_1), .video_on(von_1), .p_tick(pt_1),
    .pixel_x(x_1), .pixel_y(y_1), .line_end(le_1), .frame_end(fe_1)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset was released.
  always @(posedge clk or posedge reset) begin
    if (reset) k <= 0;
    else       k <= k + 1;
  end

  // Expected outputs after kk edges: kk/d pixel ticks have elapsed, wrapped over one frame.
  function automatic logic [25:0] model(input int kk, input int d, input int hd, input int hf,
                                        input int hs, input int hb, input int vd, input int vf,
                                        input int vs, input int vb);
    int ht, vt, p, x, y;
    logic pt, le;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    pt = ((kk % d) == d - 1);
    p  = (kk / d) % (ht * vt);
    x  = p % ht;
    y  = p / ht;
    le = pt && (x == ht - 1);
    return {!(x >= hd + hf && x < hd + hf + hs), !(y >= vd + vf && y < vd + vf + vs),
            (x < hd && y < vd), pt, le, (le && y == vt - 1), 10'(x), 10'(y)};
  endfunction

  function automatic logic [25:0] exp_d(input int kk);
    return model(kk, 4, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic logic [25:0] exp_s(input int kk);
    return model(kk, S_DIV, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB);
  endfunction

  function automatic logic [25:0] exp_1(input int kk);
    return model(kk, 1, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (obs_d !== exp_d(0)) begin errors++; $display("FAIL reset_hold_d got %h want %h", obs_d, exp_d(0)); end
    checks++;
    if (obs_s !== exp_s(0)) begin errors++; $display("FAIL reset_hold_s got %h want %h", obs_s, exp_s(0)); end
    checks++;
    if (obs_1 !== exp_1(0)) begin errors++; $display("FAIL reset_hold_1 got %h want %h", obs_1, exp_1(0)); end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (pt_d !== (k == 3 || k == 7 || k == 11)) begin
        errors++; $display("FAIL first_ticks k=%0d got %b", k, pt_d);
      end
      checks++;
      if (obs_d !== exp_d(k)) begin errors++; $display("FAIL release_d k=%0d got %h want %h", k, obs_d, exp_d(k)); end
    end
  endtask

  task automatic test_horizontal();
    int low_clk = 0;
    int fall_x = -1;
    int rise_x = -1;
    logic prev_hs = 1'b1;
    for (int i = 0; i < 3200; i++) begin
      @(negedge clk);
      checks++;
      if (obs_d !== exp_d(k)) begin errors++; $display("FAIL hline_d k=%0d got %h want %h", k, obs_d, exp_d(k)); end
      if (!hs_d) low_clk++;
      if (prev_hs && !hs_d) fall_x = int'(x_d);
      if (!prev_hs && hs_d) rise_x = int'(x_d);
      prev_hs = hs_d;
    end
    checks++;
    if (low_clk != 384) begin errors++; $display("FAIL hsync_width got %0d want 384", low_clk); end
    checks++;
    if (fall_x != 656) begin errors++; $display("FAIL hsync_fall_x got %0d want 656", fall_x); end
    checks++;
    if (rise_x != 752) begin errors++; $display("FAIL hsync_rise_x got %0d want 752", rise_x); end
  endtask

  task automatic test_line_wrap();
    int first_k = -1;
    int second_k = -1;
    int y_before;
    for (int i = 0; i < 7000 && second_k < 0; i++) begin
      @(negedge clk);
      if (le_d) begin
        y_before = int'(y_d);
        if (first_k < 0) first_k = k;
        else second_k = k;
        @(negedge clk);
        checks++;
        if (le_d !== 1'b0 || x_d !== 10'd0 || y_d !== 10'((y_before + 1) % 525)) begin
          errors++; $display("FAIL line_wrap le=%b x=%0d y=%0d want le=0 x=0 y=%0d", le_d, x_d, y_d, (y_before + 1) % 525);
        end
      end
    end
    checks++;
    if (second_k < 0 || second_k - first_k != 3200) begin
      errors++; $display("FAIL line_period got %0d want 3200", second_k - first_k);
    end
  endtask

  task automatic test_frame_wrap();
    int fe_k[$];
    int vs_low = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      checks++;
      if (obs_s !== exp_s(k)) begin errors++; $display("FAIL frame_s k=%0d got %h want %h", k, obs_s, exp_s(k)); end
      checks++;
      if (obs_1 !== exp_1(k)) begin errors++; $display("FAIL frame_1 k=%0d got %h want %h", k, obs_1, exp_1(k)); end
      checks++;
      if (obs_d !== exp_d(k)) begin errors++; $display("FAIL frame_d k=%0d got %h want %h", k, obs_d, exp_d(k)); end
      if (fe_s) fe_k.push_back(k);
      if (fe_k.size() == 1 && !vs_s) vs_low++;
    end
    checks++;
    if (fe_k.size() < 2 || fe_k[1] - fe_k[0] != 2205) begin
      errors++; $display("FAIL frame_period pulses=%0d want spacing 2205", fe_k.size());
    end
    checks++;
    if (vs_low != S_VS * 35 * S_DIV) begin
      errors++; $display("FAIL vsync_width got %0d want %0d", vs_low, S_VS * 35 * S_DIV);
    end
  endtask

  task automatic test_mid_reset();
    int run;
    for (int r = 0; r < 3; r++) begin
      run = int'($urandom_range(300, 2500));
      for (int i = 0; i < run; i++) begin
        @(negedge clk);
        checks++;
        if (obs_s !== exp_s(k)) begin errors++; $display("FAIL pre_reset_s k=%0d got %h want %h", k, obs_s, exp_s(k)); end
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if (obs_d !== exp_d(0)) begin errors++; $display("FAIL async_reset_d got %h want %h", obs_d, exp_d(0)); end
      checks++;
      if (obs_s !== exp_s(0)) begin errors++; $display("FAIL async_reset_s got %h want %h", obs_s, exp_s(0)); end
      checks++;
      if (obs_1 !== exp_1(0)) begin errors++; $display("FAIL async_reset_1 got %h want %h", obs_1, exp_1(0)); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        checks++;
        if (obs_s !== exp_s(k)) begin errors++; $display("FAIL restart_s k=%0d got %h want %h", k, obs_s, exp_s(k)); end
        checks++;
        if (pt_d !== (k == 3 || k == 7)) begin errors++; $display("FAIL restart_tick_d k=%0d got %b", k, pt_d); end
      end
    end
  endtask

  task automatic test_tick_div1();
    int last_le = -1;
    int periods = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      checks++;
      if (pt_1 !== 1'b1) begin errors++; $display("FAIL div1_tick k=%0d got %b want 1", k, pt_1); end
      checks++;
      if (obs_1 !== exp_1(k)) begin errors++; $display("FAIL div1_state k=%0d got %h want %h", k, obs_1, exp_1(k)); end
      if (le_1) begin
        if (last_le >= 0) begin
          periods++;
          checks++;
          if (k - last_le != 35) begin errors++; $display("FAIL div1_line_period got %0d want 35", k - last_le); end
        end
        last_le = k;
      end
    end
    checks++;
    if (periods < 3) begin errors++; $display("FAIL div1_line_count got %0d want >=3", periods); end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_horizontal();
    test_line_wrap();
    test_frame_wrap();
    test_mid_reset();
    test_tick_div1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
